// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mul_pkg;

   localparam int MUL_WIDTH = 32;
   localparam int MUL_N     = MUL_WIDTH / 2;
   localparam int MUL_CNT_W = $clog2(MUL_N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      BOOTH_ZERO = 3'd0,
      BOOTH_P1   = 3'd1,
      BOOTH_P2   = 3'd2,
      BOOTH_M2   = 3'd3,
      BOOTH_M1   = 3'd4
   } booth_e;

   function automatic booth_e booth_decode(input logic [2:0] triplet);
      booth_e op;
      case (triplet)
         3'b001, 3'b010: op = BOOTH_P1;
         3'b011:         op = BOOTH_P2;
         3'b100:         op = BOOTH_M2;
         3'b101, 3'b110: op = BOOTH_M1;
         default:        op = BOOTH_ZERO;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Combinational Booth partial-product selector: 0, +/-M or +/-2M in WIDTH+2 bits.
module booth_pp_sel
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic        [2:0]       triplet,
   input  logic        [WIDTH-1:0] m,
   output logic signed [WIDTH+1:0] pp
);

   logic signed [WIDTH+1:0] m1;
   logic signed [WIDTH+1:0] m2;

   // Two guard bits keep -M and -2M exact even for the most negative M.
   assign m1 = {{2{m[WIDTH-1]}}, m};
   assign m2 = {m[WIDTH-1], m, 1'b0};

   always_comb begin
      pp = '0;
      case (booth_decode(triplet))
         BOOTH_P1: pp = m1;
         BOOTH_P2: pp = m2;
         BOOTH_M2: pp = -m2;
         BOOTH_M1: pp = -m1;
         default:  pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth signed multiplier: one partial product per clock,
// WIDTH/2 steps, start/busy/done handshake, result held in hi/lo.
module booth_mul_seq
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int N     = WIDTH / 2;
   localparam int CNT_W = $clog2(N);

   state_e                  state, state_next;
   logic [WIDTH-1:0]        q;
   logic [WIDTH-1:0]        m;
   logic [2*WIDTH-1:0]      acc;
   logic [CNT_W-1:0]        k;
   logic [WIDTH:0]          q_ext;
   logic [2:0]              triplet;
   logic signed [WIDTH+1:0] pp;
   logic [2*WIDTH-1:0]      pp_ext;
   logic [2*WIDTH-1:0]      acc_next;
   logic                    last;
   logic                    accept;

   // Q[-1] = 0 sits at bit 0, so step k reads bits 2k+2..2k of q_ext.
   assign q_ext   = {q, 1'b0};
   assign triplet = q_ext[{k, 1'b0} +: 3];

   booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
      .triplet (triplet),
      .m       (m),
      .pp      (pp)
   );

   assign pp_ext   = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
   assign acc_next = acc + (pp_ext << {k, 1'b0});
   assign last     = (k == CNT_W'(N-1));
   assign accept   = start && (state == IDLE || state == DONE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) state_next = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = start ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q   <= '0;
         m   <= '0;
         acc <= '0;
         k   <= '0;
         hi  <= '0;
         lo  <= '0;
      end else if (accept) begin
         q   <= a;
         m   <= b;
         acc <= '0;
         k   <= '0;
      end else if (state == RUN) begin
         acc <= acc_next;
         k   <= k + 1'b1;
         if (last) {hi, lo} <= acc_next;
      end
   end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq against a plain signed-multiply model.
module tb_booth_mul_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;

   booth_mul_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      longint sx;
      longint sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
   endfunction

   // Accepts a start on the next edge, then samples #1 after each edge until done.
   task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int busy_cnt, output int overlap);
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; busy_cnt = 0; overlap = 0;
      for (int i = 1; i <= 40; i++) begin
         if (busy && done) overlap++;
         if (done) begin
            lat = i;
            break;
         end
         if (busy) busy_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         bad++;
         $display("FAIL reset_state: got busy=%0b done=%0b hi=%h lo=%h, want all zero", busy, done, hi, lo);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int lat, bc, ov;
      logic [63:0] hold;
      run_op(32'd3, 32'd5, lat, bc, ov);
      total++;
      if (lat != 17) begin
         bad++; $display("FAIL basic_latency: got %0d, want 17", lat);
      end
      total++;
      if (bc != 16) begin
         bad++; $display("FAIL basic_busy_cycles: got %0d, want 16", bc);
      end
      total++;
      if ({hi, lo} !== 64'h0000_0000_0000_000F) begin
         bad++; $display("FAIL basic_3x5: got %h_%h, want 00000000_0000000f", hi, lo);
      end
      hold = {hi, lo};
      repeat (5) @(posedge clk);
      #1;
      total++;
      if ({done, busy, hi, lo} !== {2'b00, hold}) begin
         bad++; $display("FAIL basic_hold_idle: got done=%0b busy=%0b %h_%h, want 0 0 %h", done, busy, hi, lo, hold);
      end
   endtask

   task automatic test_directed();
      logic [31:0] xs [6];
      logic [31:0] ys [6];
      int lat, bc, ov;
      xs = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
      ys = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF};
      for (int i = 0; i < 6; i++) begin
         run_op(xs[i], ys[i], lat, bc, ov);
         total++;
         if (lat != 17 || {hi, lo} !== ref_mul(xs[i], ys[i])) begin
            bad++;
            $display("FAIL directed_%0d: a=%h b=%h got lat=%0d %h_%h, want lat=17 %h",
                     i, xs[i], ys[i], lat, hi, lo, ref_mul(xs[i], ys[i]));
         end
      end
      // spot-check the extreme case against the literal product as well
      run_op(32'h8000_0000, 32'h8000_0000, lat, bc, ov);
      total++;
      if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
         bad++; $display("FAIL min_x_min: got %h_%h, want 40000000_00000000", hi, lo);
      end
   endtask

   task automatic test_random();
      int lat, bc, ov;
      int errs = 0;
      int overlaps = 0;
      logic [31:0] x, y;
      for (int i = 0; i < 40; i++) begin
         x = $urandom;
         y = $urandom;
         if (i % 8 == 1) x = {x[31], 31'h0};
         if (i % 8 == 2) y = {~y[31], {31{y[31]}}};
         run_op(x, y, lat, bc, ov);
         overlaps += ov;
         total++;
         if (lat != 17 || {hi, lo} !== ref_mul(x, y)) begin
            bad++;
            errs++;
            if (errs <= 5)
               $display("FAIL random_%0d: a=%h b=%h got lat=%0d %h_%h, want lat=17 %h",
                        i, x, y, lat, hi, lo, ref_mul(x, y));
         end
      end
      total++;
      if (overlaps != 0) begin
         bad++; $display("FAIL busy_done_overlap: got %0d cycles with both high, want 0", overlaps);
      end
   endtask

   task automatic test_busy_ignore();
      int dones = 0;
      logic [63:0] res = '0;
      @(negedge clk);
      a = 32'd6; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 25; i++) begin
         if (done) begin
            dones++;
            res = {hi, lo};
         end
         @(negedge clk);
         a = $urandom; b = $urandom;
         if (i == 3) begin
            a = 32'd2; b = 32'd2; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      total++;
      if (dones != 1) begin
         bad++; $display("FAIL busy_done_count: got %0d, want 1", dones);
      end
      total++;
      if (res !== 64'd42) begin
         bad++; $display("FAIL busy_result: got %h, want 000000000000002a", res);
      end
   endtask

   task automatic test_back_to_back();
      int lat = 0;
      @(negedge clk);
      a = 32'd5; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (done) begin
            lat = i;
            break;
         end
         @(posedge clk); #1;
      end
      total++;
      if (lat != 17 || {hi, lo} !== 64'd35) begin
         bad++; $display("FAIL b2b_first: got lat=%0d %h_%h, want lat=17 0000000000000023", lat, hi, lo);
      end
      a = 32'hFFFF_FFFC; b = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         bad++; $display("FAIL b2b_restart: got busy=%0b done=%0b, want 1 0", busy, done);
      end
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         if (done) begin
            lat = i;
            break;
         end
         @(posedge clk); #1;
      end
      total++;
      if (lat != 17 || {hi, lo} !== ref_mul(32'hFFFF_FFFC, 32'd9)) begin
         bad++; $display("FAIL b2b_second: got lat=%0d %h_%h, want lat=17 ffffffffffffffdc", lat, hi, lo);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bc, ov;
      int dones = 0;
      @(negedge clk);
      a = 32'd100; b = 32'd100; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         bad++; $display("FAIL reset_mid: got busy=%0b done=%0b hi=%h lo=%h, want all zero", busy, done, hi, lo);
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done || busy) dones++;
         @(posedge clk); #1;
      end
      total++;
      if (dones != 0) begin
         bad++; $display("FAIL reset_mid_quiet: got %0d active cycles, want 0", dones);
      end
      @(negedge clk);
      reset = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL reset_over_start: got busy=%0b, want 0", busy);
      end
      run_op(32'd100, 32'd100, lat, bc, ov);
      total++;
      if (lat != 17 || {hi, lo} !== 64'h0000_0000_0000_2710) begin
         bad++; $display("FAIL reset_recover: got lat=%0d %h_%h, want lat=17 0000000000002710", lat, hi, lo);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_directed();
      test_random();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
